// File: rtl/ens_vote_pkg.sv
// Shared types and helpers for the ensemble vote/argmax output stage.
// Holds the FSM encoding, the summed-score width rule and the s_data slice offset.
package ens_vote_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUM  = 2'd1,
    ST_SCAN = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  // Wide enough for every member at full scale, so the class sums cannot overflow.
  function automatic int calc_sum_w(input int num_ens, input int out_bits);
    return $clog2(num_ens * ((1 << out_bits) - 1) + 1);
  endfunction

  function automatic int score_lsb(input int e, input int c,
                                   input int num_classes, input int out_bits);
    return (e * num_classes + c) * out_bits;
  endfunction

endpackage

// File: rtl/ens_class_adder.sv
// Combinational sum of one class score across all ensemble members.
// Each member score is zero-extended to SUM_W before it is added.
module ens_class_adder
  import ens_vote_pkg::*;
#(
  parameter int NUM_ENS  = 2,
  parameter int OUT_BITS = 2,
  parameter int SUM_W    = calc_sum_w(NUM_ENS, OUT_BITS)
) (
  input  logic [NUM_ENS*OUT_BITS-1:0] i_scores,
  output logic [SUM_W-1:0]            o_sum
);

  always_comb begin
    o_sum = '0;
    for (int e = 0; e < NUM_ENS; e++) begin
      o_sum = o_sum + SUM_W'(i_scores[e*OUT_BITS +: OUT_BITS]);
    end
  end

endmodule

// File: rtl/ens_vote_argmax.sv
// Ensemble vote: register one score vector, sum classes across members,
// then scan one class per cycle for the strict-greater argmax.
//
// state   | meaning
// IDLE    | ready for a new score vector
// SUM     | class sums registered, scan seeded with class 0
// SCAN    | compare one class per cycle, ties keep the lower index
// OUT     | result held until the consumer takes it
module ens_vote_argmax
  import ens_vote_pkg::*;
#(
  parameter int NUM_ENS     = 2,
  parameter int NUM_CLASSES = 10,
  parameter int OUT_BITS    = 2,
  parameter int SUM_W       = calc_sum_w(NUM_ENS, OUT_BITS),
  parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic [NUM_ENS*NUM_CLASSES*OUT_BITS-1:0] s_data,
  output logic                                  m_valid,
  input  logic                                  m_ready,
  output logic [IDX_W-1:0]                      m_class,
  output logic [SUM_W-1:0]                      m_score
);

  localparam int DATA_W = NUM_ENS * NUM_CLASSES * OUT_BITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DATA_W-1:0]   r_data;
  logic [SUM_W-1:0]    r_sum [NUM_CLASSES];
  logic [SUM_W-1:0]    w_sum [NUM_CLASSES];
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    r_best_idx;
  logic [SUM_W-1:0]    r_best_val;
  logic                r_m_valid;
  logic [SUM_W-1:0]    w_cand;
  logic                w_scan_last;

  // Regroup the member-major input register into one member vector per class.
  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_cls
    logic [NUM_ENS*OUT_BITS-1:0] w_scores;
    for (genvar e = 0; e < NUM_ENS; e++) begin : g_mem
      assign w_scores[e*OUT_BITS +: OUT_BITS] =
        r_data[score_lsb(e, c, NUM_CLASSES, OUT_BITS) +: OUT_BITS];
    end
    ens_class_adder #(
      .NUM_ENS  (NUM_ENS),
      .OUT_BITS (OUT_BITS),
      .SUM_W    (SUM_W)
    ) u_adder (
      .i_scores (w_scores),
      .o_sum    (w_sum[c])
    );
  end

  assign w_cand      = r_sum[r_idx];
  assign w_scan_last = (r_idx == LAST_IDX);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (s_valid)     w_state_nxt = ST_SUM;
      ST_SUM:                   w_state_nxt = ST_SCAN;
      ST_SCAN: if (w_scan_last) w_state_nxt = ST_OUT;
      ST_OUT:  if (m_ready)     w_state_nxt = ST_IDLE;
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_data     <= '0;
      r_idx      <= '0;
      r_best_idx <= '0;
      r_best_val <= '0;
      r_m_valid  <= 1'b0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        r_sum[c] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (s_valid) begin
            r_data <= s_data;
          end
        end
        ST_SUM: begin
          for (int c = 0; c < NUM_CLASSES; c++) begin
            r_sum[c] <= w_sum[c];
          end
          r_best_idx <= '0;
          r_best_val <= w_sum[0];
          r_idx      <= IDX_W'(1);
        end
        ST_SCAN: begin
          if (w_cand > r_best_val) begin
            r_best_idx <= r_idx;
            r_best_val <= w_cand;
          end
          // Hold at the last class rather than wrapping past it.
          if (!w_scan_last) begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
      r_m_valid <= (w_state_nxt == ST_OUT);
    end
  end

  assign s_ready = (r_state == ST_IDLE);
  assign m_valid = r_m_valid;
  assign m_class = r_best_idx;
  assign m_score = r_best_val;

endmodule
